// File: rtl/fpu_pkg.sv
// Shared constants, state encoding and result helpers for the FP multiply controller.
package fpu_pkg;

    localparam logic [9:0]  EXP_BIAS  = 10'd127;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam int FLAG_INVALID   = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [31:0] inf_of(input logic sign);
        return {sign, EXP_MAX, 23'd0};
    endfunction

    function automatic logic [31:0] zero_of(input logic sign);
        return {sign, 31'd0};
    endfunction

endpackage

// File: rtl/fpu_mul_ctrl_if.sv
// Dispatch-side operand handshake and writeback-side result handshake.
interface fpu_mul_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [2:0]  out_flags;

    modport slave (
        input  in_valid, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_flags
    );

    modport master (
        output in_valid, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_flags
    );
endinterface

// File: rtl/FloatingMultiply.sv
// Combinational single-precision multiplier core (truncating, no special-case handling;
// callers screen NaN/Inf/zero and exponent range before trusting the result).
module FloatingMultiply (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result
);
    logic [24:0] prod_hi_s;
    logic [7:0]  exp_s;
    logic [22:0] mant_s;

    assign prod_hi_s = 25'(({24'd0, 1'b1, A[22:0]} * {24'd0, 1'b1, B[22:0]}) >> 23);
    assign exp_s     = A[30:23] + B[30:23] - 8'd127 + {7'd0, prod_hi_s[24]};
    assign mant_s    = prod_hi_s[24] ? prod_hi_s[23:1] : prod_hi_s[22:0];
    assign result    = {A[31] ^ B[31], exp_s, mant_s};
endmodule

// File: rtl/fpu_mul_classify.sv
// IEEE-754 special-case screen and biased exponent sum for a multiply operand pair.
module fpu_mul_classify
    import fpu_pkg::*;
#(
    parameter logic [31:0] NAN_RESULT = 32'h7FC0_0000
) (
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    output logic [1:0]        is_nan,
    output logic [1:0]        is_inf,
    output logic [1:0]        is_zero,
    output logic              special_hit,
    output logic [31:0]       special_result,
    output logic              invalid,
    output logic signed [9:0] esum
);
    logic sign_s;

    assign sign_s     = a[31] ^ b[31];
    assign is_nan[0]  = (a[30:23] == EXP_MAX) && (a[22:0] != 23'd0);
    assign is_nan[1]  = (b[30:23] == EXP_MAX) && (b[22:0] != 23'd0);
    assign is_inf[0]  = (a[30:23] == EXP_MAX) && (a[22:0] == 23'd0);
    assign is_inf[1]  = (b[30:23] == EXP_MAX) && (b[22:0] == 23'd0);
    // Exponent 0 covers denormals, which are flushed to zero.
    assign is_zero[0] = (a[30:23] == 8'd0);
    assign is_zero[1] = (b[30:23] == 8'd0);
    assign esum       = $signed({2'b00, a[30:23]} + {2'b00, b[30:23]} - EXP_BIAS);

    // Priority: NaN, then Inf x zero, then Inf, then zero.
    always_comb begin
        special_hit    = 1'b0;
        special_result = 32'd0;
        invalid        = 1'b0;
        if (|is_nan) begin
            special_hit    = 1'b1;
            special_result = NAN_RESULT;
            invalid        = 1'b1;
        end else if ((|is_inf) && (|is_zero)) begin
            special_hit    = 1'b1;
            special_result = NAN_RESULT;
            invalid        = 1'b1;
        end else if (|is_inf) begin
            special_hit    = 1'b1;
            special_result = inf_of(sign_s);
        end else if (|is_zero) begin
            special_hit    = 1'b1;
            special_result = zero_of(sign_s);
        end else begin
            special_hit    = 1'b0;
        end
    end
endmodule

// File: rtl/fpu_mul_ctrl.sv
// Issue/writeback controller around the multicycle FloatingMultiply path: screens special
// cases and exponent range, waits LATENCY cycles on the core, holds the result for writeback.
module fpu_mul_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fpu_mul_ctrl_if.slave bus
);
    localparam logic [3:0]        CNT_LOAD = 4'(LATENCY - 1);
    localparam logic signed [9:0] ESUM_MAX = 10'sd254;
    localparam logic signed [9:0] ESUM_MIN = 10'sd1;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [4:0]  rd_q, rd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  flags_q, flags_d;
    logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [31:0]       cls_a_s, cls_b_s, cls_special_result_s, core_result_s;
    logic [1:0]        cls_is_nan_s, cls_is_inf_s, cls_is_zero_s;
    logic              cls_special_hit_s, cls_invalid_s, sign_s, unused_cls_s;
    logic signed [9:0] cls_esum_s;

    // Classify the incoming pair while idle, the latched pair otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            cls_a_s = bus.in_a;
            cls_b_s = bus.in_b;
        end else begin
            cls_a_s = a_q;
            cls_b_s = b_q;
        end
    end

    assign sign_s       = cls_a_s[31] ^ cls_b_s[31];
    assign unused_cls_s = ^{cls_is_nan_s, cls_is_inf_s, cls_is_zero_s};

    fpu_mul_classify #(.NAN_RESULT(CANON_NAN)) u_classify (
        .a              (cls_a_s),
        .b              (cls_b_s),
        .is_nan         (cls_is_nan_s),
        .is_inf         (cls_is_inf_s),
        .is_zero        (cls_is_zero_s),
        .special_hit    (cls_special_hit_s),
        .special_result (cls_special_result_s),
        .invalid        (cls_invalid_s),
        .esum           (cls_esum_s)
    );

    FloatingMultiply u_core (
        .A      (a_q),
        .B      (b_q),
        .result (core_result_s)
    );

    // Next-state, operand latch, result patching and flag generation.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d  = bus.in_a;
                    b_d  = bus.in_b;
                    rd_d = bus.in_rd;
                    if (cls_special_hit_s) begin
                        state_d                = DONE;
                        result_d               = cls_special_result_s;
                        flags_d                = 3'b000;
                        flags_d[FLAG_INVALID]  = cls_invalid_s;
                    end else if (cls_esum_s > ESUM_MAX) begin
                        state_d                = DONE;
                        result_d               = inf_of(sign_s);
                        flags_d                = 3'b000;
                        flags_d[FLAG_OVERFLOW] = 1'b1;
                    end else if (cls_esum_s < ESUM_MIN) begin
                        state_d                 = DONE;
                        result_d                = zero_of(sign_s);
                        flags_d                 = 3'b000;
                        flags_d[FLAG_UNDERFLOW] = 1'b1;
                    end else begin
                        state_d = EXEC;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    // An all-ones exponent here means esum==254 plus a normalize carry.
                    if (core_result_s[30:23] == EXP_MAX) begin
                        result_d               = inf_of(sign_s);
                        flags_d                = 3'b000;
                        flags_d[FLAG_OVERFLOW] = 1'b1;
                    end else begin
                        result_d = core_result_s;
                        flags_d  = 3'b000;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    flags_d = 3'b000;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                flags_d = 3'b000;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            rd_q        <= 5'd0;
            cnt_q       <= 4'd0;
            result_q    <= 32'd0;
            flags_q     <= 3'b000;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_rd     = rd_q;
    assign bus.out_flags  = flags_q;
endmodule

// File: tb/tb_fpu_mul_ctrl.sv
// Table-driven bench for fpu_mul_ctrl with a scoreboard queue of expected writebacks.
module tb_fpu_mul_ctrl;
    localparam int LAT = 3;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];
    vec_t vecs[14];

    fpu_mul_ctrl_if bif ();

    fpu_mul_ctrl #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Present an operand pair, wait (bounded) for acceptance, optionally record the expectation.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] er, input logic [2:0] ef, input int elat,
                         input bit do_push);
        int w;
        bif.in_a     = a;
        bif.in_b     = b;
        bif.in_rd    = rd;
        bif.in_valid = 1'b1;
        w = 0;
        while (bif.in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (bif.in_ready !== 1'b1) chk("accept_timeout", 32'(bif.in_ready), 32'd1);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        if (do_push) sb_q.push_back('{er, ef, rd, elat});
    endtask

    // Wait for a result, compare against the scoreboard head, optionally stall, then hand-shake.
    task automatic collect(input int hold, input string nm);
        exp_t e;
        int   lat;
        lat = 1;
        while (bif.out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("%s out_valid", nm), 32'(bif.out_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk($sformatf("%s sb_empty", nm), 32'd0, 32'd1);
            e = '{32'd0, 3'd0, 5'd0, 0};
        end else begin
            e = sb_q.pop_front();
        end
        chk($sformatf("%s result", nm), bif.out_result, e.res);
        chk($sformatf("%s flags", nm), 32'(bif.out_flags), 32'(e.flags));
        chk($sformatf("%s rd", nm), 32'(bif.out_rd), 32'(e.rd));
        chk($sformatf("%s latency", nm), 32'(lat), 32'(e.lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk($sformatf("%s hold%0d valid", nm, i), 32'(bif.out_valid), 32'd1);
            chk($sformatf("%s hold%0d result", nm, i), bif.out_result, e.res);
            chk($sformatf("%s hold%0d in_ready", nm, i), 32'(bif.in_ready), 32'd0);
        end
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
        chk($sformatf("%s post valid", nm), 32'(bif.out_valid), 32'd0);
        chk($sformatf("%s post flags", nm), 32'(bif.out_flags), 32'd0);
        chk($sformatf("%s post in_ready", nm), 32'(bif.in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        vecs[0]  = '{32'h4000_0000, 32'h4040_0000, 5'd7,  32'h40C0_0000, 3'b000, LAT + 1};
        vecs[1]  = '{32'h3FC0_0000, 32'hBFC0_0000, 5'd3,  32'hC010_0000, 3'b000, LAT + 1};
        vecs[2]  = '{32'h7F80_0000, 32'h0000_0000, 5'd4,  32'h7FC0_0000, 3'b100, 1};
        vecs[3]  = '{32'h7F00_0000, 32'h7F00_0000, 5'd5,  32'h7F80_0000, 3'b010, 1};
        vecs[4]  = '{32'h0080_0000, 32'h0080_0000, 5'd6,  32'h0000_0000, 3'b001, 1};
        vecs[5]  = '{32'h7FA0_0001, 32'h3F80_0000, 5'd8,  32'h7FC0_0000, 3'b100, 1};
        vecs[6]  = '{32'hFF80_0000, 32'h4000_0000, 5'd9,  32'hFF80_0000, 3'b000, 1};
        vecs[7]  = '{32'h8000_0000, 32'h4040_0000, 5'd10, 32'h8000_0000, 3'b000, 1};
        vecs[8]  = '{32'h0000_0001, 32'h3F80_0000, 5'd11, 32'h0000_0000, 3'b000, 1};
        vecs[9]  = '{32'h7F40_0000, 32'h3FC0_0000, 5'd12, 32'h7F80_0000, 3'b010, LAT + 1};
        vecs[10] = '{32'h7F00_0000, 32'h3F80_0000, 5'd13, 32'h7F00_0000, 3'b000, LAT + 1};
        vecs[11] = '{32'h0080_0000, 32'h3F80_0000, 5'd14, 32'h0080_0000, 3'b000, LAT + 1};
        vecs[12] = '{32'h0080_0000, 32'h3F00_0000, 5'd15, 32'h0000_0000, 3'b001, 1};
        vecs[13] = '{32'h7FC0_0000, 32'h7F80_0000, 5'd16, 32'h7FC0_0000, 3'b100, 1};

        // Reset with in_valid asserted: nothing may be accepted.
        bif.in_valid  = 1'b1;
        bif.in_a      = 32'h4000_0000;
        bif.in_b      = 32'h4000_0000;
        bif.in_rd     = 5'd1;
        bif.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 32'(bif.in_ready), 32'd1);
        chk("rst out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst out_result", bif.out_result, 32'd0);
        chk("rst out_rd", 32'(bif.out_rd), 32'd0);
        chk("rst out_flags", 32'(bif.out_flags), 32'd0);
        bif.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, vecs[i].flags, vecs[i].lat, 1'b1);
            collect(0, $sformatf("vec%0d", i));
        end

        // Backpressure with a second request held pending the whole time.
        issue(32'h4000_0000, 32'h4000_0000, 5'd20, 32'h4080_0000, 3'b000, LAT + 1, 1'b1);
        bif.in_a     = 32'h3F80_0000;
        bif.in_b     = 32'h4000_0000;
        bif.in_rd    = 5'd21;
        bif.in_valid = 1'b1;
        collect(5, "bp");
        issue(32'h3F80_0000, 32'h4000_0000, 5'd21, 32'h4000_0000, 3'b000, LAT + 1, 1'b1);
        collect(0, "bp_next");

        // Reset mid-EXEC drops the in-flight operation.
        issue(32'h4000_0000, 32'h4040_0000, 5'd22, 32'd0, 3'b000, 0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst in_ready", 32'(bif.in_ready), 32'd1);
        chk("midrst out_valid", 32'(bif.out_valid), 32'd0);
        chk("midrst out_result", bif.out_result, 32'd0);
        chk("midrst out_flags", 32'(bif.out_flags), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bif.out_valid === 1'b1) seen++;
        end
        chk("midrst dropped", 32'(seen), 32'd0);
        issue(32'h3F80_0000, 32'h4120_0000, 5'd23, 32'h4120_0000, 3'b000, LAT + 1, 1'b1);
        collect(0, "after_rst");

        chk("sb drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/fpu_mul_ctrl.md
Name: fpu_mul_ctrl

Overview:
Sequential issue and writeback controller for the single-precision FP multiply in the EX stage of the pipelined RISC-V core. It accepts operands from the FPU dispatch with a valid/ready handshake and screens IEEE-754 special cases. It then drives the team's combinational multiplier core (FloatingMultiply: A, B → result) and allows LATENCY cycles for that multicycle path. Finally it patches out-of-range exponents and holds the registered result plus flags until writeback accepts it.

Parameters:
LATENCY, 2, cycles the operands are held stable at the core before the product is sampled (1..15)
CANON_NAN, 32'h7FC00000, quiet NaN returned for invalid operations

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  controller can accept operands
in_a  in  32  operand A, IEEE-754 single
in_b  in  32  operand B, IEEE-754 single
in_rd  in  5  destination register tag, passed through
out_valid  out  1  result valid
out_ready  in  1  writeback accepts result
out_result  out  32  product
out_rd  out  5  destination tag
out_flags  out  3  {invalid, overflow, underflow}

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_rd=0, out_flags=0, counter=0. Reset wins over every other event, including mid-EXEC and mid-DONE; the in-flight operation is dropped with no output.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch a, b, rd.
    - If a special case applies, go to DONE with the forced result (1-cycle latency).
    - Otherwise go to EXEC and load counter=LATENCY-1.
  - EXEC: in_ready=0. The latched operands drive the core. Counter decrements each cycle. When counter==0, register the patched core result and go to DONE. Normal-path latency from accept to out_valid is LATENCY+1 cycles.
  - DONE: out_valid=1; outputs stay stable while out_ready=0. On out_ready, go to IDLE with out_valid=0.
  - No accept occurs in the same cycle as DONE→IDLE; in_ready rises the following cycle.
- Special-case classification, from the latched operands. Exponent 0 is treated as zero (denormals flush to zero). Sign is always sa^sb, except for NaN.
  - Either operand is NaN (exp=FF, mant≠0): result CANON_NAN, invalid=1.
  - Inf × zero: result CANON_NAN, invalid=1.
  - Inf × finite nonzero: result {s, FF, 0}.
  - Zero × finite: result {s, 00, 0}.
- Exponent guard. Compute esum = ea + eb − 127 as a 10-bit signed value.
  - esum > 254: result {s, FF, 0}, overflow=1, without waiting on the core.
  - esum < 1: result {s, 00, 0}, underflow=1.
  - Otherwise use the core result. If the core exponent field reads FF (esum==254 plus normalize carry), force {s, FF, 0} and set overflow=1.
- Flags are valid only with out_valid and clear on leaving DONE.
- Simultaneous in_valid with reset: reset wins and nothing is accepted. in_valid while busy is ignored; dispatch must hold it.

Decomposition:
- Shared package fpu_pkg holds:
  - constants EXP_BIAS=127, EXP_MAX=8'hFF, CANON_NAN
  - the state enum {IDLE, EXEC, DONE}
  - the flag bit indices
- One sub-module: fpu_mul_classify (combinational). It takes a and b and returns is_nan, is_inf, is_zero, special_hit, special_result, invalid and esum.
- FloatingMultiply is instantiated unchanged.

Test Plan:
- 0x40000000 × 0x40400000, out_ready=1 → out_result=0x40C00000, flags=000, out_valid exactly LATENCY+1 cycles after accept; in_rd=7 → out_rd=7.
- 0x3FC00000 × 0xBFC00000 → 0xC0100000 (−2.25); then 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1, 1-cycle latency.
- 0x7F000000 × 0x7F000000 → 0x7F800000, overflow=1; 0x00800000 × 0x00800000 → 0x00000000, underflow=1.
- Backpressure: 0x40000000 × 0x40000000 with out_ready=0 for 5 cycles → out_valid=1 and out_result=0x40800000 held stable; in_ready=0 throughout; a second in_valid is not accepted until the cycle after the out_ready handshake.
- Reset mid-EXEC (rst_n=0 one cycle, LATENCY=3) → next cycle in_ready=1, out_valid=0, out_result=0. The dropped op never appears; a following 0x3F800000 × 0x41200000 → 0x41200000.
- NaN propagation: 0x7FA00001 × 0x3F800000 → 0x7FC00000, invalid=1.
